// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, instruction-memory write port and status
// of the boot loader. "slave" is the loader side; "master" is the side that
// feeds the byte stream and observes the writes and status.
interface imem_loader_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic [ADDR_W:0]   length;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_reset;
  logic              busy;
  logic              error;

  modport slave (
    input  start, length, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_reset, busy, error
  );

  modport master (
    output start, length, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_reset, busy, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory filler. Assembles big-endian
// 32-bit words from a valid/ready byte stream, writes one word per WRITE cycle
// and holds the core in reset until the requested number of words is written.
// Optional feature: define LOADER_CHECKSUM_EN to add a trailing XOR checksum
// word (CHECK state) that gates release of the core reset.
module imem_loader #(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 7
) (
  input logic          i_clk,
  input logic          i_rst,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH_WORDS);

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_word_cnt;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_word;
  logic              r_byte_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_cpu_reset;
  logic              r_busy;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       r_csum;
  logic              r_error;
`endif

  logic [ADDR_W:0]   w_len;
  logic              w_xfer;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_cnt_inc;

  // Clamp the requested length so a write past the last word cannot happen.
  assign w_len     = (bus.length > LEN_MAX) ? LEN_MAX : bus.length;
  assign w_xfer    = bus.byte_valid & r_byte_ready;
  assign w_word    = {r_word, bus.byte_in};
  assign w_cnt_inc = r_word_cnt + (ADDR_W+1)'(1);

  assign bus.byte_ready = r_byte_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.cpu_reset  = r_cpu_reset;
  assign bus.busy       = r_busy;
`ifdef LOADER_CHECKSUM_EN
  assign bus.error      = r_error;
`else
  assign bus.error      = 1'b0;
`endif

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_cpu_reset  <= 1'b1;
      r_busy       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
      r_error      <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_len       <= w_len;
            r_word_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_cpu_reset <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= '0;
            r_error     <= 1'b0;
`endif
            if (w_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
              // Empty program still needs its (zero) checksum word.
              r_state      <= S_CHECK;
              r_byte_ready <= 1'b1;
              r_busy       <= 1'b1;
`else
              r_state      <= S_DONE;
              r_cpu_reset  <= 1'b0;
              r_busy       <= 1'b0;
`endif
            end else begin
              r_state      <= S_LOAD;
              r_byte_ready <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_word     <= w_word[23:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state      <= S_WRITE;
              r_byte_ready <= 1'b0;
              r_wr_en      <= 1'b1;
              r_wr_addr    <= r_word_cnt[ADDR_W-1:0];
              r_wr_data    <= w_word;
            end
          end
        end
        S_WRITE: begin
          r_word_cnt   <= w_cnt_inc;
          r_byte_ready <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
          r_csum       <= r_csum ^ r_wr_data;
`endif
          if (w_cnt_inc == r_len) begin
`ifdef LOADER_CHECKSUM_EN
            r_state      <= S_CHECK;
`else
            r_state      <= S_DONE;
            r_byte_ready <= 1'b0;
            r_cpu_reset  <= 1'b0;
            r_busy       <= 1'b0;
`endif
          end else begin
            r_state <= S_LOAD;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_xfer) begin
            r_word     <= w_word[23:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state      <= S_DONE;
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_error      <= (w_word != r_csum);
              r_cpu_reset  <= (w_word != r_csum);
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with a write scoreboard.
// Build with LOADER_CHECKSUM_EN defined to cover the checksum variant.
module tb_imem_loader;
  localparam int AW = 7;
`ifdef LOADER_CHECKSUM_EN
  localparam int CS = 4;
`else
  localparam int CS = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus();
  imem_loader #(.DEPTH_WORDS(128), .ADDR_W(AW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         exp_q[$];
  int          wr_cyc[$];
  int          cyc = 0;
  int          vectors = 0;
  int          errs = 0;
  int          t0;
  logic [31:0] csum;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every WrEn cycle pops one expected write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      vectors++;
      if (exp_q.size() == 0) begin
        errs++;
        $error("FAIL wr_unexpected: got addr %0d data %h, want no write", bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        assert (bus.wr_addr === e.a && bus.wr_data === e.d) else begin
          errs++;
          $error("FAIL wr_data: got addr %0d data %h, want addr %0d data %h",
                 bus.wr_addr, bus.wr_data, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int a, input logic [31:0] d);
    exp_q.push_back('{a: AW'(a), d: d});
    csum = csum ^ d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    int n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.byte_ready === 1'b1) got = 1;
    end
    if (!got) chk("byte_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int stall_b = -1, input int stall_n = 0);
    for (int b = 0; b < 4; b++) begin
      send_byte(w[31-8*b -: 8]);
      if (b == stall_b) begin
        bus.byte_valid = 1'b0;
        repeat (stall_n) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_cs();
`ifdef LOADER_CHECKSUM_EN
    send_word(csum);
`endif
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start(input int len);
    t0 = cyc;
    bus.start  = 1'b1;
    bus.length = (AW+1)'(len);
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) chk({tag, "_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_wren"},  32'(bus.wr_en),      32'd0);
    chk({tag, "_addr"},  32'(bus.wr_addr),    32'd0);
    chk({tag, "_data"},  bus.wr_data,         32'd0);
    chk({tag, "_cpurst"},32'(bus.cpu_reset),  32'd1);
    chk({tag, "_busy"},  32'(bus.busy),       32'd0);
    chk({tag, "_error"}, 32'(bus.error),      32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    bus.start = 1'b0; bus.length = '0; bus.byte_in = '0; bus.byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk); #1;

    // Back-to-back stream: writes at +5/+10, core released at +11 (+CS).
    csum = 0; wr_cyc.delete();
    push(0, 32'h20080005); push(1, 32'h8C090004);
    do_start(2);
    send_word(32'h20080005); send_word(32'h8C090004); send_cs();
    wait_done("t1");
    chk("t1_fall", 32'(cyc - t0), 32'(11 + CS));
    chk("t1_nwr", 32'(wr_cyc.size()), 32'd2);
    chk("t1_wr0", 32'((wr_cyc.size() > 0) ? wr_cyc[0] - t0 : -1), 32'd5);
    chk("t1_wr1", 32'((wr_cyc.size() > 1) ? wr_cyc[1] - t0 : -1), 32'd10);
    chk("t1_cpurst", 32'(bus.cpu_reset), 32'd0);
    chk("t1_q", 32'(exp_q.size()), 32'd0);

    // Same load, 3-cycle valid stall after byte 2.
    csum = 0; wr_cyc.delete();
    push(0, 32'h20080005); push(1, 32'h8C090004);
    do_start(2);
    send_word(32'h20080005, 1, 3); send_word(32'h8C090004); send_cs();
    wait_done("t2");
    chk("t2_fall", 32'(cyc - t0), 32'(14 + CS));
    chk("t2_wr0", 32'((wr_cyc.size() > 0) ? wr_cyc[0] - t0 : -1), 32'd8);
    chk("t2_wr1", 32'((wr_cyc.size() > 1) ? wr_cyc[1] - t0 : -1), 32'd13);
    chk("t2_q", 32'(exp_q.size()), 32'd0);

    // Length 200 clamps to 128 words.
    csum = 0; wr_cyc.delete();
    do_start(200);
    for (int i = 0; i < 128; i++) begin
      w = (32'(i) * 32'h01030507) ^ 32'hA55A0000;
      push(i, w);
      send_word(w);
    end
    send_cs();
    wait_done("t3");
    chk("t3_nwr", 32'(wr_cyc.size()), 32'd128);
    chk("t3_q", 32'(exp_q.size()), 32'd0);
    chk("t3_cpurst", 32'(bus.cpu_reset), 32'd0);
    // Bytes offered in DONE are refused.
    bus.byte_valid = 1'b1; bus.byte_in = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("t3_ready_done", 32'(bus.byte_ready), 32'd0);
    end
    bus.byte_valid = 1'b0;
    @(posedge clk); #1;

    // Reset after byte 6 of a 2-word load.
    csum = 0; wr_cyc.delete();
    push(0, 32'h01020304);
    do_start(2);
    send_word(32'h01020304); send_byte(8'hAA); send_byte(8'hBB);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("t4");
    chk("t4_nwr", 32'(wr_cyc.size()), 32'd1);
    chk("t4_q", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    csum = 0; wr_cyc.delete();
    push(0, 32'hDEADBEEF);
    do_start(1);
    send_word(32'hDEADBEEF); send_cs();
    wait_done("t4r");
    chk("t4r_nwr", 32'(wr_cyc.size()), 32'd1);
    chk("t4r_q", 32'(exp_q.size()), 32'd0);
    chk("t4r_cpurst", 32'(bus.cpu_reset), 32'd0);

    // Start pulsed mid-load is ignored.
    csum = 0; wr_cyc.delete();
    push(0, 32'h11223344); push(1, 32'h55667788);
    do_start(2);
    send_byte(8'h11); send_byte(8'h22);
    bus.start = 1'b1; bus.length = 8'd1;
    send_byte(8'h33);
    bus.start = 1'b0;
    send_byte(8'h44); send_word(32'h55667788); send_cs();
    wait_done("t5");
    chk("t5_nwr", 32'(wr_cyc.size()), 32'd2);
    chk("t5_q", 32'(exp_q.size()), 32'd0);

    // Length 0.
    csum = 0; wr_cyc.delete();
    do_start(0);
    @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
    chk("t6_busy", 32'(bus.busy), 32'd1);
    chk("t6_ready", 32'(bus.byte_ready), 32'd1);
    @(posedge clk); #1;
    send_word(32'h0); bus.byte_valid = 1'b0;
    wait_done("t6");
    chk("t6_error", 32'(bus.error), 32'd0);
`else
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_ready", 32'(bus.byte_ready), 32'd0);
`endif
    chk("t6_cpurst", 32'(bus.cpu_reset), 32'd0);
    chk("t6_nwr", 32'(wr_cyc.size()), 32'd0);
    @(posedge clk); #1;

    // Start coincident with reset: reset wins.
    bus.start = 1'b1; bus.length = 8'd2; rst = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("t7_busy", 32'(bus.busy), 32'd0);
    chk("t7_cpurst", 32'(bus.cpu_reset), 32'd1);
    chk("t7_ready", 32'(bus.byte_ready), 32'd0);
    @(posedge clk); #1;

`ifdef LOADER_CHECKSUM_EN
    // Good checksum.
    csum = 0;
    push(0, 32'h1); push(1, 32'h3);
    do_start(2);
    send_word(32'h1); send_word(32'h3); send_word(32'h2); bus.byte_valid = 1'b0;
    wait_done("c1");
    chk("c1_error", 32'(bus.error), 32'd0);
    chk("c1_cpurst", 32'(bus.cpu_reset), 32'd0);
    // Bad checksum.
    csum = 0;
    push(0, 32'h1); push(1, 32'h3);
    do_start(2);
    send_word(32'h1); send_word(32'h3); send_word(32'h0); bus.byte_valid = 1'b0;
    wait_done("c2");
    chk("c2_error", 32'(bus.error), 32'd1);
    chk("c2_cpurst", 32'(bus.cpu_reset), 32'd1);
    chk("c2_q", 32'(exp_q.size()), 32'd0);
    // A new Start clears Error.
    do_start(0);
    @(negedge clk);
    chk("c3_error", 32'(bus.error), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that fills instruction memory before the pipeline runs. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and issues single-cycle word writes to the instruction memory write port. It holds the processor core in reset until the programmed number of words has been written. It sits beside the instruction memory: the core is the reader, this block is the writer.

## Interface
- DEPTH_WORDS, 128: instruction memory depth in words; must be a power of two.
- ADDR_W, 7: word-address width, log2(DEPTH_WORDS).
- Clk  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high; sampled only on the rising edge of Clk.
- Start  input  1  one-cycle pulse; begins a load; honoured only in IDLE or DONE.
- Length  input  ADDR_W+1  number of program words; sampled on the accepted Start.
- ByteIn  input  8  stream byte.
- ByteValid  input  1  ByteIn is valid.
- ByteReady  output  1  loader accepts ByteIn this cycle; a byte transfers when ByteValid & ByteReady.
- WrEn  output  1  instruction memory write strobe; one cycle per word.
- WrAddr  output  ADDR_W  word address of the write.
- WrData  output  32  word written.
- CpuReset  output  1  holds the core (PC and pipeline registers) in reset.
- Busy  output  1  load in progress (LOAD, WRITE or CHECK).
- Error  output  1  checksum mismatch; always 0 when checksum is compiled out.

## Operation
- States: IDLE, LOAD, WRITE, CHECK (checksum build only), DONE.
- Reset: state IDLE.
  - ByteReady=0, WrEn=0, WrAddr=0, WrData=0, CpuReset=1, Busy=0, Error=0.
  - Byte counter=0, word counter=0.
- IDLE/DONE + Start:
  - Latch Len = min(Length, DEPTH_WORDS).
  - Clear the word counter, byte counter and Error. Set CpuReset=1.
  - If Len=0, go to DONE (or CHECK in the checksum build). Otherwise go to LOAD.
- LOAD:
  - ByteReady=1.
  - Each accepted byte shifts into the word assembly register, MSB first: word = {word[23:0], ByteIn}.
  - The byte counter increments modulo 4.
  - On the 4th accepted byte, go to WRITE.
- WRITE (one cycle):
  - WrEn=1, WrAddr = word counter, WrData = assembled word. ByteReady=0.
  - The word counter increments.
  - If the counter reaches Len, go to DONE (or CHECK in the checksum build). Otherwise return to LOAD.
- DONE: CpuReset=0, unless Error=1, in which case CpuReset stays 1. ByteReady=0.
- Bytes offered outside LOAD are not accepted and are not consumed.
- Start is ignored while Busy=1.
- Start coincident with Reset: Reset wins.
- Reset mid-load:
  - Abort on the next edge and return to reset values.
  - Memory words already written are left as written. Partial words are discarded.
- WrAddr wraps naturally within ADDR_W bits. Because Len is clamped, a write past DEPTH_WORDS-1 never occurs.

## Timing
- 4th byte accepted on edge N: WrEn is high for the cycle following edge N and drops after edge N+1.
- Next byte acceptance is possible from the cycle after WRITE.
- Minimum cycles per word: 5 (4 transfers + 1 write cycle).
- CpuReset deasserts in the first DONE cycle, i.e. the cycle after the final WRITE (or after CHECK).
- ByteValid stalls of any length are legal. State is held while ByteValid=0.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last program word, CHECK receives one further 4-byte big-endian word with the same handshake. No WrEn is issued for it.
  - A running XOR of all written words is compared against this word. A mismatch sets Error=1.
  - Then go to DONE. CpuReset stays 1 if Error=1.
  - Len=0 still requires the checksum word; the expected value is 0.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK state and no checksum register. Error is constant 0.

## Test plan
- Reset then Start, Length=2, bytes 20 08 00 05 8C 09 00 04 with ByteValid=1 continuously:
  - WrEn at addr 0 with 0x20080005, then at addr 1 with 0x8C090004.
  - CpuReset falls 11 cycles after the Start edge.
- Same load with ByteValid dropped for 3 cycles after the 2nd byte:
  - Identical writes, delayed 3 cycles. No byte duplicated or lost.
- Length=200 with DEPTH_WORDS=128:
  - Exactly 128 writes, addresses 0..127. DONE is reached after the 128th write.
- Reset asserted after the 6th byte of a Length=2 load:
  - Exactly one write (addr 0). All outputs return to reset values.
  - A new Start reloads from addr 0.
- Start pulsed during LOAD: ignored, write sequence unchanged. Length=0: DONE the cycle after Start, no WrEn.
- LOADER_CHECKSUM_EN, words 0x00000001 and 0x00000003:
  - Checksum 0x00000002 gives Error=0 and CpuReset=0.
  - Checksum 0x00000000 gives Error=1 and CpuReset held at 1.
